// File: rtl/sd_spi_responder_if.sv
// ---------------------------------------------------------------------------
// sd_spi_responder_if
//
// SPI-mode SD card bus between a host (master) and a card (slave).
//   sclk  : SPI clock, host -> card (mode 0)
//   cs_n  : chip select, active-low, host -> card
//   mosi  : host -> card data
//   miso  : card -> host data
// ---------------------------------------------------------------------------
interface sd_spi_responder_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;

  modport master (
    output sclk,
    output cs_n,
    output mosi,
    input  miso
  );

  modport slave (
    input  sclk,
    input  cs_n,
    input  mosi,
    output miso
  );
endinterface

// File: rtl/sd_spi_responder.sv
// ---------------------------------------------------------------------------
// sd_spi_responder
//
// Card-side model of an SD card in SPI mode. The host's SCLK/CS/MOSI are
// resynchronised into the clk domain, 48-bit command frames are decoded,
// the card init state (POWERUP/IDLE/READY) is tracked and an R1 response is
// returned on MISO after NCR bytes of 0xFF fill.
//
// Parameters
//   NCR         fill bytes (0xFF) between frame end and R1 (1..8)
//   INIT_POLLS  CMD1 count in IDLE before the card reports ready (1..15)
//
// Ports
//   clk         system clock (SCLK must be at most clk/8)
//   rst         synchronous active-high reset
//   spi         SPI bus, slave side (sclk/cs_n/mosi asynchronous in, miso out)
//   cmd_valid   one-clk pulse when a complete frame has been decoded
//   cmd_index   command index of the last frame (held)
//   cmd_arg     argument of the last frame (held)
//   crc_err     CRC7 mismatch flag of the last frame (held)
//   card_state  00 POWERUP, 01 IDLE, 10 READY
//   r1          last R1 value loaded for transmission (held)
// ---------------------------------------------------------------------------
module sd_spi_responder #(
  parameter int NCR        = 1,
  parameter int INIT_POLLS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  sd_spi_responder_if.slave        spi,
  output logic                     cmd_valid,
  output logic [5:0]               cmd_index,
  output logic [31:0]              cmd_arg,
  output logic                     crc_err,
  output logic [1:0]               card_state,
  output logic [7:0]               r1
);

  localparam logic [1:0] ST_POWERUP = 2'b00;
  localparam logic [1:0] ST_IDLE    = 2'b01;
  localparam logic [1:0] ST_READY   = 2'b10;

  localparam int              TX_BITS   = (NCR + 1) * 8;
  localparam int              TX_CW     = $clog2(TX_BITS + 1);
  localparam logic [TX_CW-1:0] TX_LOAD  = TX_CW'(TX_BITS);
  localparam logic [3:0]      POLL_LOAD = 4'(INIT_POLLS);

  // Idle levels of {sclk, cs_n, mosi} used as synchronizer reset values so
  // that reset never creates a spurious SCLK edge or CS assertion.
  localparam logic [2:0] SYNC_INIT = 3'b010;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    CMD  = 2'd1,
    RESP = 2'd2
  } rx_state_t;

  // -------------------------------------------------------------------------
  // Input conditioning: 2-flop synchronizers on sclk, cs_n and mosi
  // -------------------------------------------------------------------------
  logic [2:0] raw_in;
  logic [2:0] sync_bus;

  assign raw_in = {spi.sclk, spi.cs_n, spi.mosi};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          meta_reg <= SYNC_INIT[gi];
          sync_reg <= SYNC_INIT[gi];
        end else begin
          meta_reg <= raw_in[gi];
          sync_reg <= meta_reg;
        end
      end

      assign sync_bus[gi] = sync_reg;
    end
  endgenerate

  logic sclk_s;
  logic cs_active;
  logic mosi_s;
  logic sclk_dly_reg;
  logic sclk_rise;
  logic sclk_fall;

  assign sclk_s    = sync_bus[2];
  assign cs_active = ~sync_bus[1];
  assign mosi_s    = sync_bus[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_dly_reg <= 1'b0;
    end else begin
      sclk_dly_reg <= sclk_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_dly_reg;
  assign sclk_fall = ~sclk_s & sclk_dly_reg;

  // -------------------------------------------------------------------------
  // Bit counter and receive shifter
  // -------------------------------------------------------------------------
  logic [2:0] bit_cnt_reg;
  logic [6:0] shift_reg;
  logic [7:0] rx_byte;
  logic       byte_done;
  logic       start_byte;

  // rx_byte is the byte completed by the current rise (MSB first).
  assign rx_byte    = {shift_reg, mosi_s};
  assign byte_done  = cs_active & sclk_rise & (bit_cnt_reg == 3'd7);
  assign start_byte = (rx_byte[7:6] == 2'b01);

  always_ff @(posedge clk) begin
    if (rst || !cs_active) begin
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
    end else if (sclk_rise) begin
      bit_cnt_reg <= bit_cnt_reg + 3'd1;
      shift_reg   <= rx_byte[6:0];
    end
  end

  // -------------------------------------------------------------------------
  // Receiver FSM: state register
  // -------------------------------------------------------------------------
  rx_state_t state_reg;
  rx_state_t state_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= HUNT;
    end else begin
      state_reg <= state_next;
    end
  end

  // Frame storage, byte counter, CRC and held status registers
  logic [2:0]        byte_cnt_reg;
  logic [37:0]       frame_reg;
  logic [6:0]        crc_reg;
  logic [TX_BITS-1:0] tx_sr_reg;
  logic [TX_CW-1:0]  tx_cnt_reg;
  logic              miso_reg;
  logic              cmd_valid_reg;
  logic [5:0]        cmd_index_reg;
  logic [31:0]       cmd_arg_reg;
  logic              crc_err_reg;
  logic [1:0]        card_state_reg;
  logic [7:0]        r1_reg;
  logic [3:0]        poll_reg;

  // Decoded frame fields (valid when frame_end is high)
  logic [5:0]  frame_index;
  logic        frame_crc_bad;

  assign frame_index   = frame_reg[37:32];
  assign frame_crc_bad = (crc_reg != rx_byte[7:1]);

  // Output/decode signals of the FSM
  logic       frame_end;
  logic       crc_update;
  logic       tx_step;
  logic       respond;
  logic [7:0] r1_calc;
  logic [1:0] card_state_next;
  logic [3:0] poll_next;

  // -------------------------------------------------------------------------
  // Receiver FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    if (!cs_active) begin
      state_next = HUNT;
    end else begin
      case (state_reg)
        HUNT: if (byte_done && start_byte) state_next = CMD;
        CMD:  if (frame_end) state_next = respond ? RESP : HUNT;
        // The fall after R1 bit 0 restores miso and ends the response.
        RESP: if (sclk_fall && tx_cnt_reg == '0) state_next = HUNT;
        default: state_next = HUNT;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Receiver FSM: output / command decode logic
  // -------------------------------------------------------------------------
  always_comb begin
    frame_end       = (state_reg == CMD) && byte_done && (byte_cnt_reg == 3'd5);
    // CRC covers byte 1 (seen in HUNT) and bytes 2..5 (byte_cnt 1..4).
    crc_update      = cs_active && sclk_rise &&
                      ((state_reg == HUNT) ||
                       ((state_reg == CMD) && (byte_cnt_reg <= 3'd4)));
    tx_step         = (state_reg == RESP) && sclk_fall;
    respond         = 1'b1;
    r1_calc         = 8'h00;
    card_state_next = card_state_reg;
    poll_next       = poll_reg;

    case (card_state_reg)
      ST_POWERUP: begin
        if (frame_index == 6'd0 && !frame_crc_bad) begin
          card_state_next = ST_IDLE;
          poll_next       = POLL_LOAD;
          r1_calc         = 8'h01;
        end else if (frame_index == 6'd0) begin
          r1_calc = 8'h09;
        end else begin
          respond = 1'b0;
        end
      end
      ST_IDLE: begin
        if (frame_index == 6'd0 && frame_crc_bad) begin
          r1_calc = 8'h09;
        end else if (frame_index == 6'd0) begin
          poll_next = POLL_LOAD;
          r1_calc   = 8'h01;
        end else if (frame_index == 6'd1) begin
          poll_next = poll_reg - 4'd1;
          if (poll_next == 4'd0) begin
            card_state_next = ST_READY;
            r1_calc         = 8'h00;
          end else begin
            r1_calc = 8'h01;
          end
        end else begin
          r1_calc = 8'h05;
        end
      end
      ST_READY: begin
        if (frame_index == 6'd0 && frame_crc_bad) begin
          r1_calc = 8'h08;
        end else if (frame_index == 6'd0) begin
          card_state_next = ST_IDLE;
          poll_next       = POLL_LOAD;
          r1_calc         = 8'h01;
        end else if (frame_index == 6'd1) begin
          r1_calc = 8'h00;
        end else begin
          r1_calc = 8'h04;
        end
      end
      default: begin
        // Unused encoding: fall back to power-up behaviour.
        card_state_next = ST_POWERUP;
        respond         = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Frame assembly and CRC7 (x^7 + x^3 + 1, init 0), one bit per SCLK rise
  // -------------------------------------------------------------------------
  logic [6:0] crc_base;
  logic [6:0] crc_step;

  // In HUNT every byte is a potential frame start, so the CRC restarts at
  // each byte boundary until a start byte is accepted.
  assign crc_base = (state_reg == HUNT && bit_cnt_reg == 3'd0) ? 7'd0 : crc_reg;
  assign crc_step = {crc_base[5:0], 1'b0} ^ ({7{crc_base[6] ^ mosi_s}} & 7'h09);

  always_ff @(posedge clk) begin
    if (rst || !cs_active) begin
      crc_reg <= '0;
    end else if (crc_update) begin
      crc_reg <= crc_step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !cs_active) begin
      byte_cnt_reg <= '0;
      frame_reg    <= '0;
    end else if (byte_done) begin
      if (state_reg == HUNT && start_byte) begin
        byte_cnt_reg <= 3'd1;
        frame_reg    <= {32'd0, rx_byte[5:0]};
      end else if (state_reg == CMD) begin
        byte_cnt_reg <= byte_cnt_reg + 3'd1;
        if (byte_cnt_reg <= 3'd4) begin
          frame_reg <= {frame_reg[29:0], rx_byte};
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Held status outputs and card state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_valid_reg  <= 1'b0;
      cmd_index_reg  <= '0;
      cmd_arg_reg    <= '0;
      crc_err_reg    <= 1'b0;
      card_state_reg <= ST_POWERUP;
      r1_reg         <= '0;
      poll_reg       <= POLL_LOAD;
    end else begin
      cmd_valid_reg <= frame_end;
      if (frame_end) begin
        cmd_index_reg  <= frame_index;
        cmd_arg_reg    <= frame_reg[31:0];
        crc_err_reg    <= frame_crc_bad;
        card_state_reg <= card_state_next;
        poll_reg       <= poll_next;
        if (respond) begin
          r1_reg <= r1_calc;
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Response transmitter: NCR fill bytes then R1, one bit per SCLK fall
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst || !cs_active) begin
      miso_reg   <= 1'b1;
      tx_sr_reg  <= '1;
      tx_cnt_reg <= '0;
    end else if (frame_end && respond) begin
      tx_sr_reg  <= {{(NCR * 8){1'b1}}, r1_calc};
      tx_cnt_reg <= TX_LOAD;
    end else if (tx_step) begin
      if (tx_cnt_reg != '0) begin
        miso_reg   <= tx_sr_reg[TX_BITS-1];
        tx_sr_reg  <= {tx_sr_reg[TX_BITS-2:0], 1'b1};
        tx_cnt_reg <= tx_cnt_reg - 1'b1;
      end else begin
        miso_reg <= 1'b1;
      end
    end
  end

  assign spi.miso   = miso_reg;
  assign cmd_valid  = cmd_valid_reg;
  assign cmd_index  = cmd_index_reg;
  assign cmd_arg    = cmd_arg_reg;
  assign crc_err    = crc_err_reg;
  assign card_state = card_state_reg;
  assign r1         = r1_reg;

endmodule

// File: tb/tb_sd_spi_responder.sv
// ---------------------------------------------------------------------------
// tb_sd_spi_responder
//
// Host-side bench for sd_spi_responder. A host task bit-bangs SPI frames;
// expected decode results are queued per frame and checked by a monitor on
// each cmd_valid pulse. MISO bytes are checked as the host reads them.
// ---------------------------------------------------------------------------
module tb_sd_spi_responder;
  localparam int NCR        = 1;
  localparam int INIT_POLLS = 2;
  localparam int HALF       = 50;   // SCLK half period, 5 clk periods

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        crc_err;
  logic [1:0]  card_state;
  logic [7:0]  r1;

  sd_spi_responder_if spi_bus ();

  sd_spi_responder #(
    .NCR        (NCR),
    .INIT_POLLS (INIT_POLLS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .spi        (spi_bus),
    .cmd_valid  (cmd_valid),
    .cmd_index  (cmd_index),
    .cmd_arg    (cmd_arg),
    .crc_err    (crc_err),
    .card_state (card_state),
    .r1         (r1)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        crc_err;
    logic [1:0]  state;
    logic [7:0]  r1;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference card model
  int         m_state;   // 0 POWERUP, 1 IDLE, 2 READY
  int         m_poll;
  logic [7:0] m_r1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // CRC7 as the remainder of message * x^7 divided by x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_of(input logic [39:0] d);
    logic [46:0] m;
    m = {d, 7'd0};
    for (int i = 46; i >= 7; i--) begin
      if (m[i]) m = m ^ (47'h89 << (i - 7));
    end
    return m[6:0];
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_poll  = INIT_POLLS;
    m_r1    = 8'h00;
  endtask

  task automatic model_cmd(input logic [5:0] idx, input bit crc_ok,
                           output bit respond, output logic [7:0] r);
    respond = 1'b1;
    r       = 8'h00;
    if (idx == 0 && !crc_ok) begin
      r = (m_state == 2) ? 8'h08 : 8'h09;
    end else if (idx == 0) begin
      m_state = 1;
      m_poll  = INIT_POLLS;
      r       = 8'h01;
    end else if (m_state == 0) begin
      respond = 1'b0;
    end else if (idx == 1) begin
      if (m_state == 1) begin
        m_poll = m_poll - 1;
        if (m_poll == 0) m_state = 2;
      end
      r = (m_state == 2) ? 8'h00 : 8'h01;
    end else begin
      r = (m_state == 2) ? 8'h04 : 8'h05;
    end
    if (respond) m_r1 = r;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      spi_bus.mosi = tx[i];
      #HALF spi_bus.sclk = 1'b1;
      rx[i] = spi_bus.miso;
      #HALF spi_bus.sclk = 1'b0;
    end
  endtask

  // frame_bytes < 6 aborts the frame; resp_bytes limits bytes read after it.
  task automatic run_frame(input logic [5:0] idx, input logic [31:0] arg,
                           input logic [7:0] crc_xor, input int frame_bytes,
                           input int resp_bytes, input bit hold_cs);
    logic [7:0] fb [6];
    logic [7:0] rx;
    logic [7:0] r;
    logic [7:0] want;
    bit         respond;
    bit         crc_ok;
    int         n_resp;
    exp_t       e;

    fb[0] = {2'b01, idx};
    fb[1] = arg[31:24];
    fb[2] = arg[23:16];
    fb[3] = arg[15:8];
    fb[4] = arg[7:0];
    fb[5] = {crc7_of({2'b01, idx, arg}), 1'b1} ^ crc_xor;
    crc_ok  = (crc_xor[7:1] == 7'd0);
    respond = 1'b0;
    r       = 8'h00;

    if (frame_bytes == 6) begin
      model_cmd(idx, crc_ok, respond, r);
      e.idx     = idx;
      e.arg     = arg;
      e.crc_err = !crc_ok;
      e.state   = 2'(m_state);
      e.r1      = m_r1;
      exp_q.push_back(e);
    end

    spi_bus.cs_n = 1'b0;
    #(2 * HALF);
    for (int b = 0; b < frame_bytes; b++) begin
      spi_byte(fb[b], rx);
      check("miso_during_cmd", rx, 8'hFF);
    end

    if (frame_bytes == 6) begin
      n_resp = respond ? NCR + 2 : 8;
      if (n_resp > resp_bytes) n_resp = resp_bytes;
      for (int k = 0; k < n_resp; k++) begin
        spi_byte(8'hFF, rx);
        want = (respond && k == NCR) ? r : 8'hFF;
        check((respond && k == NCR) ? "miso_r1" : "miso_fill", rx, want);
      end
    end

    $display("frame cmd%0d arg=%08h crc=%02h sent=%0d resp=%0b r1=%02h state=%0d",
             idx, arg, fb[5], frame_bytes, respond, r, m_state);

    if (!hold_cs) begin
      #(2 * HALF);
      spi_bus.cs_n = 1'b1;
      #(4 * HALF);
      check("cmd_valid_count", exp_q.size(), 0);
    end
  endtask

  // Scoreboard monitor: every cmd_valid pulse consumes one expected frame.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      if (cmd_valid) begin
        check("cmd_valid_width", prev_valid, 1'b0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL cmd_valid_unexpected: got pulse, expected none (index 0x%0h)", cmd_index);
        end else begin
          mon_e = exp_q.pop_front();
          check("cmd_index", cmd_index, mon_e.idx);
          check("cmd_arg", cmd_arg, mon_e.arg);
          check("crc_err", crc_err, mon_e.crc_err);
          check("card_state", card_state, mon_e.state);
          check("r1", r1, mon_e.r1);
        end
      end
      prev_valid <= cmd_valid;
    end
  end

  initial begin
    logic       bit_rx;
    logic [5:0] ridx;
    logic [7:0] rxor;
    int         sel;

    spi_bus.sclk = 1'b0;
    spi_bus.cs_n = 1'b1;
    spi_bus.mosi = 1'b1;
    model_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_miso", spi_bus.miso, 1'b1);
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_cmd_index", cmd_index, 6'd0);
    check("rst_cmd_arg", cmd_arg, 32'd0);
    check("rst_crc_err", crc_err, 1'b0);
    check("rst_card_state", card_state, 2'b00);
    check("rst_r1", r1, 8'h00);

    // 80 clocks with CS high must not disturb anything
    for (int i = 0; i < 80; i++) begin
      #HALF spi_bus.sclk = 1'b1;
      #HALF spi_bus.sclk = 1'b0;
    end
    #(2 * HALF);
    check("precs_miso", spi_bus.miso, 1'b1);
    check("precs_state", card_state, 2'b00);

    // Directed sequence
    run_frame(6'd1,  32'd0, 8'h00, 6, 99, 1'b0);  // no response in POWERUP
    run_frame(6'd0,  32'd0, 8'h94, 6, 99, 1'b0);  // CRC byte 0x01 -> 0x09
    run_frame(6'd0,  32'd0, 8'h00, 6, 99, 1'b0);  // -> IDLE, 0x01
    run_frame(6'd17, 32'd0, 8'h00, 6, 99, 1'b0);  // IDLE -> 0x05
    run_frame(6'd1,  32'd0, 8'h00, 6, 99, 1'b0);  // 0x01
    run_frame(6'd1,  32'd0, 8'h00, 6, 99, 1'b0);  // -> READY, 0x00
    run_frame(6'd1,  32'd0, 8'h00, 6, 99, 1'b0);  // 0x00
    run_frame(6'd17, 32'd0, 8'h00, 6, 99, 1'b0);  // READY -> 0x04
    run_frame(6'd0,  32'd0, 8'h00, 3, 99, 1'b0);  // aborted after 3 bytes
    run_frame(6'd0,  32'd0, 8'h00, 6, 99, 1'b0);  // -> IDLE, 0x01
    check("dir_state_idle", card_state, 2'b01);

    // Randomized frames, bad CRCs and aborts
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(0, 3);
      ridx = (sel == 0) ? 6'd0 : (sel == 1) ? 6'd1 : (sel == 2) ? 6'd17
                                            : 6'($urandom_range(0, 63));
      rxor = ($urandom_range(0, 3) == 0) ? {7'($urandom_range(1, 127)), 1'b0} : 8'h00;
      sel = $urandom_range(0, 7);
      if (sel == 0)
        run_frame(ridx, $urandom, rxor, $urandom_range(1, 5), 99, 1'b0);
      else if (sel == 1)
        run_frame(ridx, $urandom, rxor, 6, 1, 1'b0);
      else
        run_frame(ridx, $urandom, rxor, 6, 99, 1'b0);
    end

    // Reset in the middle of an R1 byte
    run_frame(6'd0, 32'd0, 8'h00, 6, NCR, 1'b1);
    for (int i = 0; i < 2; i++) begin
      #HALF spi_bus.sclk = 1'b1;
      bit_rx = spi_bus.miso;
      check("r1_lead_bit", bit_rx, 1'b0);
      #HALF spi_bus.sclk = 1'b0;
    end
    #(HALF / 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_r1_miso", spi_bus.miso, 1'b1);
    check("rst_mid_r1_state", card_state, 2'b00);
    check("rst_mid_r1_r1", r1, 8'h00);
    spi_bus.cs_n = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    model_reset();
    exp_q.delete();
    @(negedge clk);
    run_frame(6'd0, 32'd0, 8'h00, 6, 99, 1'b0);
    check("final_state_idle", card_state, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
